image_uart_tx: RTL

IMAGE_UART_TX -- requirements
Module: image_uart_tx

---
 rtl/image_uart_tx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/image_uart_tx.sv
// Streams NUM_BYTES bytes from DRAM, starting at START_ADDR, out of an 8N1 UART line.
// Each byte is fetched with a single outstanding read. It is then framed as a start bit,
// eight data bits sent LSB first, and one stop bit. A one-cycle done pulse follows the
// final stop bit.
module image_uart_tx #(
  parameter logic [15:0] START_ADDR   = 16'h0000,
  parameter logic [16:0] NUM_BYTES    = 17'd16384,
  parameter logic [15:0] CLKS_PER_BIT = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  input  logic [7:0]  mem_din,
  input  logic        mem_valid,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStart,
    StData,
    StStop,
    StDone
  } state_e;

  state_e      state_q;
  logic [15:0] addr_q;
  logic [16:0] count_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic [15:0] baud_q;
  logic        baud_last;

  assign baud_last = (baud_q == CLKS_PER_BIT - 16'd1);

  // The read address is the address register itself, so it stays stable for the whole FETCH.
  assign mem_addr = addr_q;

  // This block holds the sequencer. All outputs are registered and are set on the edge
  // that enters each state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      addr_q    <= 16'h0000;
      count_q   <= 17'd0;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      baud_q    <= 16'd0;
      mem_read  <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            addr_q   <= START_ADDR;
            count_q  <= NUM_BYTES;
            baud_q   <= 16'd0;
            mem_read <= 1'b1;
            busy     <= 1'b1;
            state_q  <= StFetch;
          end
        end
        StFetch: begin
          if (mem_valid) begin
            shift_q  <= mem_din;
            mem_read <= 1'b0;
            tx       <= 1'b0;
            baud_q   <= 16'd0;
            state_q  <= StStart;
          end
        end
        StStart: begin
          if (baud_last) begin
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            tx        <= shift_q[0];
            state_q   <= StData;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        StData: begin
          if (baud_last) begin
            baud_q <= 16'd0;
            if (bit_idx_q == 3'd7) begin
              tx      <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx        <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        StStop: begin
          if (baud_last) begin
            baud_q  <= 16'd0;
            count_q <= count_q - 17'd1;
            // Natural 16-bit overflow gives the FFFF -> 0000 wrap.
            addr_q  <= addr_q + 16'd1;
            if (count_q != 17'd1) begin
              mem_read <= 1'b1;
              state_q  <= StFetch;
            end else begin
              done    <= 1'b1;
              state_q <= StDone;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
